tpu_instr_dispatch: RTL and testbench
=====================================

TPU_INSTR_DISPATCH -- requirements
Module: tpu_instr_dispatch

Interface
REQ-001 Parameter INSTR_W, default 32, instruction payload width.
REQ-002 Parameter ID_W, default 8, thread ID width (ID_W <= INSTR_W).
REQ-003 Parameter ISSUE_W, default 8, MPU issue number width (ISSUE_W <= INSTR_W).
REQ-004 Parameter ADDR_W, default 10, instruction memory address width.
REQ-005 Port clock  in  1  clock; reset, synchronous, active-high; clock clock.
REQ-006 Port reset  in  1  synchronous active-high reset.
REQ-007 Port I_Start  in  1  start a dispatch; sampled only in IDLE.
REQ-008 Port I_Abort  in  1  abandon the current dispatch.
REQ-009 Port I_IssueNo  in  ISSUE_W  issue number, latched at start.
REQ-010 Port I_ThreadID  in  ID_W  SIMT thread ID, latched at start.
REQ-011 Port I_Base  in  ADDR_W  first instruction address, latched at start.
REQ-012 Port I_Len  in  ADDR_W+1  instruction count L, 0..2^ADDR_W, latched at start.
REQ-013 Port O_Rd_En  out  1  memory read strobe; data is returned on I_Rd_Data in the following cycle.
REQ-014 Port O_Rd_Addr  out  ADDR_W  memory read address.
REQ-015 Port I_Rd_Data  in  INSTR_W  memory read data.
REQ-016 Port O_Req  out  1  transfer window to the TPU front-end.
REQ-017 Port O_Instr  out  INSTR_W+1  {v, payload}; bit INSTR_W is the valid bit.
REQ-018 Port I_Nack  in  1  front-end rejects the word presented in this cycle.
REQ-019 Port O_Term  out  1  one-cycle end-of-transfer pulse.
REQ-020 Port O_Busy  out  1  dispatch in progress.

Function
REQ-021 Word stream, W = L+2 words:
- w0 = issue number, zero-extended.
- w1 = thread ID, zero-extended.
- w(k+2) = mem[(Base+k) mod 2^ADDR_W], k = 0..L-1.
REQ-022 States are IDLE, XFER, REPLAY and TERM.
REQ-023 IDLE with I_Start=1 at cycle c:
- latch the inputs;
- XFER at c+1, presenting w0 with v=1.
REQ-024 Word w presented in XFER at cycle c with I_Nack=0 is accepted:
- if w+1 < W, present w+1 at c+1;
- otherwise go to TERM at c+1.
REQ-025 Read timing:
- an instruction word is read one cycle ahead;
- O_Rd_En=1 at cycle c when w+1 >= 2 and w+1 < W, with O_Rd_Addr = Base+(w+1-2) mod 2^ADDR_W;
- the read is speculative, issued regardless of I_Nack.
REQ-026 For instruction words, the O_Instr payload is I_Rd_Data through a registered select with no extra register; header payloads come from the latched registers.
REQ-027 Word w presented with I_Nack=1 at cycle c:
- REPLAY at c+1, with O_Instr.v=0 and O_Req=1;
- w is re-presented in XFER at c+2;
- in REPLAY, O_Rd_En=1 with the address of w when w >= 2, else 0.
REQ-028 I_Nack is ignored in REPLAY and TERM; repeated Nacks repeat the replay indefinitely.
REQ-029 TERM lasts exactly one cycle with O_Term=1, O_Req=0, O_Instr.v=0 and O_Busy=1, then IDLE.
REQ-030 O_Req=1 and O_Busy=1 in XFER and REPLAY; O_Req=0 in IDLE and TERM.
REQ-031 I_Start is ignored unless in IDLE.
REQ-032 I_Abort=1 in any non-IDLE state causes IDLE at the next cycle with no O_Term pulse; I_Abort has priority over I_Nack and over the end-of-stream transition.
REQ-033 L=0 sends headers only, with no memory reads.
REQ-034 L=2^ADDR_W is legal; the address wraps modulo 2^ADDR_W.
REQ-035 The word index counter is ADDR_W+2 bits wide and must not overflow for W up to 2^ADDR_W+2.
REQ-036 No combinational path from I_Nack to O_Rd_En, O_Rd_Addr or O_Req.

Reset
REQ-037 Reset returns to IDLE.
REQ-038 Reset clears O_Req, O_Instr, O_Term, O_Busy, O_Rd_En, O_Rd_Addr and all latched registers to 0.
REQ-039 Reset has priority over I_Start and I_Abort.
REQ-040 Reset mid-transfer gives O_Req=0 in the next cycle with no O_Term pulse.

Verification
REQ-041 Start at c0 (IssueNo=0x5, TID=0x2A, Base=0x010, L=3), no Nack:
- c1 {1,0x5}, c2 {1,0x2A}, c3-c5 mem[0x010..0x012];
- O_Rd_En at c2-c4 with addresses 0x010, 0x011, 0x012;
- c6 O_Term=1, O_Req=0; c7 O_Busy=0.
REQ-042 L=0:
- c1 w0, c2 w1, c3 O_Term=1;
- O_Rd_En never asserted.
REQ-043 Same setup as REQ-041, I_Nack=1 at c4 (w3):
- c5 v=0 with O_Rd_En at 0x011;
- c6 mem[0x011], c7 mem[0x012], c8 O_Term=1.
REQ-044 I_Nack=1 at c1 (w0):
- c2 v=0 with O_Rd_En=0;
- c3 w0 re-presented; O_Term at c8 for L=3.
REQ-045 Base=0x3FF, L=2, ADDR_W=10 -> read addresses 0x3FF then 0x000.
REQ-046 Abort and restart:
- I_Abort=1 at c3 -> c4 O_Req=0, O_Busy=0, O_Term=0;
- I_Start at c2 is ignored;
- I_Start at c4 begins a new stream with w0 at c5.

Source files
------------

// File: rtl/tpu_instr_dispatch.sv
// Instruction dispatcher: streams issue number, thread ID, then L memory
// words to the TPU front-end, replaying any word the front-end rejects.
//
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   I_Start, I_Abort      begin a dispatch (IDLE only) / abandon it
//   I_IssueNo, I_ThreadID header values, latched at start
//   I_Base, I_Len         first address and word count L, latched at start
//   O_Rd_En, O_Rd_Addr    memory read strobe/address (data next cycle)
//   I_Rd_Data             memory read data
//   O_Req, O_Instr        transfer window and {valid, payload}
//   I_Nack                front-end rejects the presented word
//   O_Term, O_Busy        end-of-transfer pulse, dispatch in progress
module tpu_instr_dispatch #(
   parameter int INSTR_W = 32,
   parameter int ID_W    = 8,
   parameter int ISSUE_W = 8,
   parameter int ADDR_W  = 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               I_Start,
   input  logic               I_Abort,
   input  logic [ISSUE_W-1:0] I_IssueNo,
   input  logic [ID_W-1:0]    I_ThreadID,
   input  logic [ADDR_W-1:0]  I_Base,
   input  logic [ADDR_W:0]    I_Len,
   output logic               O_Rd_En,
   output logic [ADDR_W-1:0]  O_Rd_Addr,
   input  logic [INSTR_W-1:0] I_Rd_Data,
   output logic               O_Req,
   output logic [INSTR_W:0]   O_Instr,
   input  logic               I_Nack,
   output logic               O_Term,
   output logic               O_Busy
);

   localparam int IDX_W = ADDR_W + 2;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      REPLAY,
      TERM
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [ISSUE_W-1:0] issue;
   logic [ID_W-1:0]    tid;
   logic [ADDR_W-1:0]  base;
   logic [ADDR_W:0]    len;
   logic [INSTR_W-1:0] hdr;
   logic               valid;
   logic               from_mem;

   logic [IDX_W-1:0]   words;
   logic [IDX_W-1:0]   nxt;
   logic [IDX_W-1:0]   nxt2;
   logic               stop;

   assign words = {1'b0, len} + IDX_W'(2);
   assign nxt   = idx + IDX_W'(1);
   assign nxt2  = idx + IDX_W'(2);
   assign stop  = (state == TERM) ||
                  ((state != IDLE) && I_Abort);

   // Memory words are forwarded straight from the read port; only the
   // select is registered, so the read must be issued one cycle ahead.
   assign O_Instr = {valid, from_mem ? I_Rd_Data : hdr};

   // Address of stream word w (w >= 2), wrapping modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] addr_of(
      input logic [IDX_W-1:0]  w,
      input logic [ADDR_W-1:0] b
   );
      logic [IDX_W-1:0] t;
      t = {2'b00, b} + w - IDX_W'(2);
      return t[ADDR_W-1:0];
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         issue     <= '0;
         tid       <= '0;
         base      <= '0;
         len       <= '0;
         hdr       <= '0;
         valid     <= 1'b0;
         from_mem  <= 1'b0;
         O_Req     <= 1'b0;
         O_Busy    <= 1'b0;
         O_Term    <= 1'b0;
         O_Rd_En   <= 1'b0;
         O_Rd_Addr <= '0;
      end else if (stop) begin
         state   <= IDLE;
         valid   <= 1'b0;
         O_Req   <= 1'b0;
         O_Busy  <= 1'b0;
         O_Term  <= 1'b0;
         O_Rd_En <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (I_Start) begin
                  issue    <= I_IssueNo;
                  tid      <= I_ThreadID;
                  base     <= I_Base;
                  len      <= I_Len;
                  idx      <= '0;
                  hdr      <= INSTR_W'(I_IssueNo);
                  from_mem <= 1'b0;
                  valid    <= 1'b1;
                  O_Req    <= 1'b1;
                  O_Busy   <= 1'b1;
                  O_Term   <= 1'b0;
                  O_Rd_En  <= 1'b0;
                  state    <= XFER;
               end
            end
            XFER: begin
               if (I_Nack) begin
                  // Re-read the rejected word so it is ready again.
                  state     <= REPLAY;
                  valid     <= 1'b0;
                  O_Rd_En   <= idx >= IDX_W'(2);
                  O_Rd_Addr <= addr_of(idx, base);
               end else if (nxt < words) begin
                  idx      <= nxt;
                  from_mem <= nxt >= IDX_W'(2);
                  if (nxt == IDX_W'(1))
                     hdr <= INSTR_W'(tid);
                  // Speculative read of the word after the next one.
                  O_Rd_En   <= nxt2 < words;
                  O_Rd_Addr <= addr_of(nxt2, base);
               end else begin
                  state   <= TERM;
                  valid   <= 1'b0;
                  O_Req   <= 1'b0;
                  O_Term  <= 1'b1;
                  O_Rd_En <= 1'b0;
               end
            end
            REPLAY: begin
               state    <= XFER;
               valid    <= 1'b1;
               from_mem <= idx >= IDX_W'(2);
               hdr      <= (idx == '0) ? INSTR_W'(issue)
                                       : INSTR_W'(tid);
               O_Rd_En   <= (nxt >= IDX_W'(2)) && (nxt < words);
               O_Rd_Addr <= addr_of(nxt, base);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tpu_instr_dispatch.sv
// Self-checking bench for tpu_instr_dispatch: a word-list reference model
// checked every cycle, directed scenarios with literal expectations, random.
module tb_tpu_instr_dispatch;

   localparam int INSTR_W = 32;
   localparam int ID_W    = 8;
   localparam int ISSUE_W = 8;
   localparam int ADDR_W  = 10;
   localparam int DEPTH   = 1 << ADDR_W;

   logic               clock = 1'b0;
   logic               reset;
   logic               start;
   logic               abort;
   logic [ISSUE_W-1:0] issue_no;
   logic [ID_W-1:0]    thread_id;
   logic [ADDR_W-1:0]  base;
   logic [ADDR_W:0]    len;
   logic               rd_en;
   logic [ADDR_W-1:0]  rd_addr;
   logic [INSTR_W-1:0] rd_data;
   logic               req;
   logic [INSTR_W:0]   instr;
   logic               nack;
   logic               term;
   logic               busy;

   always #5 clock = ~clock;

   tpu_instr_dispatch #(
      .INSTR_W(INSTR_W),
      .ID_W(ID_W),
      .ISSUE_W(ISSUE_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .clock(clock),
      .reset(reset),
      .I_Start(start),
      .I_Abort(abort),
      .I_IssueNo(issue_no),
      .I_ThreadID(thread_id),
      .I_Base(base),
      .I_Len(len),
      .O_Rd_En(rd_en),
      .O_Rd_Addr(rd_addr),
      .I_Rd_Data(rd_data),
      .O_Req(req),
      .O_Instr(instr),
      .I_Nack(nack),
      .O_Term(term),
      .O_Busy(busy)
   );

   logic [INSTR_W-1:0] mem [DEPTH];

   always @(posedge clock)
      if (rd_en) rd_data <= mem[rd_addr];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc_no = 0;

   // model: 0 idle, 1 presenting, 2 replay, 3 term
   bit                 m_known = 0;
   int                 m_mode;
   int                 m_pos;
   int                 m_w;
   int                 m_base;
   logic [INSTR_W-1:0] m_words [DEPTH+2];

   logic [ISSUE_W-1:0] d_iss;
   logic [ID_W-1:0]    d_tid;
   logic [ADDR_W-1:0]  d_base;
   logic [ADDR_W:0]    d_len;

   int                 tcyc;
   int                 term_at;
   logic [INSTR_W:0]   o_instr [16];
   logic               o_rd_en [16];
   logic [ADDR_W-1:0]  o_rd_addr [16];
   logic               o_req [16];
   logic               o_term [16];
   logic               o_busy [16];

   task automatic chk(input string name,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                  name, cyc_no, got, exp);
      end
   endtask

   task automatic model_check();
      bit e_rd;
      int e_addr;
      e_rd = 0;
      e_addr = 0;
      chk("req", 64'(req), 64'(m_mode == 1 || m_mode == 2));
      chk("busy", 64'(busy), 64'(m_mode != 0));
      chk("term", 64'(term), 64'(m_mode == 3));
      chk("valid", 64'(instr[INSTR_W]), 64'(m_mode == 1));
      if (m_mode == 1) begin
         chk("payload", 64'(instr[INSTR_W-1:0]), 64'(m_words[m_pos]));
         e_rd = (m_pos + 1 >= 2) && (m_pos + 1 < m_w);
         e_addr = (m_base + m_pos - 1) % DEPTH;
      end else if (m_mode == 2) begin
         e_rd = m_pos >= 2;
         e_addr = (m_base + m_pos - 2) % DEPTH;
      end
      chk("rd_en", 64'(rd_en), 64'(e_rd));
      if (e_rd) chk("rd_addr", 64'(rd_addr), 64'(e_addr));
   endtask

   task automatic model_step(input bit r, input bit s,
                             input bit a, input bit n);
      if (r) begin
         m_known = 1;
         m_mode = 0;
      end else if (m_known) begin
         case (m_mode)
            0: if (s) begin
               m_base = int'(d_base);
               m_w = int'(d_len) + 2;
               m_words[0] = INSTR_W'(d_iss);
               m_words[1] = INSTR_W'(d_tid);
               for (int k = 0; k < int'(d_len); k++)
                  m_words[k+2] = mem[(m_base + k) % DEPTH];
               m_mode = 1;
               m_pos = 0;
            end
            1: if (a) m_mode = 0;
               else if (n) m_mode = 2;
               else if (m_pos + 1 < m_w) m_pos++;
               else m_mode = 3;
            2: m_mode = a ? 0 : 1;
            default: m_mode = 0;
         endcase
      end
   endtask

   task automatic tick(input bit r, input bit s,
                       input bit a, input bit n);
      @(negedge clock);
      if (m_known) model_check();
      if (tcyc < 16) begin
         o_instr[tcyc]   = instr;
         o_rd_en[tcyc]   = rd_en;
         o_rd_addr[tcyc] = rd_addr;
         o_req[tcyc]     = req;
         o_term[tcyc]    = term;
         o_busy[tcyc]    = busy;
      end
      if (term === 1'b1) term_at = tcyc;
      reset     = r;
      start     = s;
      abort     = a;
      nack      = n;
      issue_no  = d_iss;
      thread_id = d_tid;
      base      = d_base;
      len       = d_len;
      model_step(r, s, a, n);
      tcyc++;
      cyc_no++;
   endtask

   task automatic setup(input logic [7:0] i, input logic [7:0] t,
                        input logic [9:0] b, input logic [10:0] l);
      d_iss = i;
      d_tid = t;
      d_base = b;
      d_len = l;
      tcyc = 0;
   endtask

   initial begin
      int cnt;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC0DE_0000 + i;
      rd_data = '0;
      reset = 1'b1;
      start = 0;
      abort = 0;
      nack = 0;
      setup(8'h0, 8'h0, 10'h0, 11'h0);
      term_at = -1;

      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      tcyc = 0;
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      chk("rst_instr", 64'(o_instr[0]), 64'h0);
      chk("rst_addr", 64'(o_rd_addr[0]), 64'h0);
      chk("rst_outs", 64'({o_req[0], o_busy[0], o_term[0], o_rd_en[0]}), 64'h0);

      // basic stream, L=3
      setup(8'h05, 8'h2A, 10'h010, 11'd3);
      tick(0, 1, 0, 0);
      repeat (8) tick(0, 0, 0, 0);
      chk("t1_c1", 64'(o_instr[1]), 64'h1_0000_0005);
      chk("t1_c2", 64'(o_instr[2]), 64'h1_0000_002A);
      chk("t1_c3", 64'(o_instr[3]), 64'h1_C0DE_0010);
      chk("t1_c5", 64'(o_instr[5]), 64'h1_C0DE_0012);
      chk("t1_rd2", 64'({o_rd_en[2], o_rd_addr[2]}), 64'h410);
      chk("t1_rd3", 64'({o_rd_en[3], o_rd_addr[3]}), 64'h411);
      chk("t1_rd4", 64'({o_rd_en[4], o_rd_addr[4]}), 64'h412);
      chk("t1_term6", 64'({o_term[6], o_req[6]}), 64'h2);
      chk("t1_busy7", 64'(o_busy[7]), 64'h0);

      // headers only
      setup(8'h11, 8'h22, 10'h020, 11'd0);
      tick(0, 1, 0, 0);
      repeat (5) tick(0, 0, 0, 0);
      cnt = 0;
      for (int i = 0; i < 6; i++) cnt += int'(o_rd_en[i]);
      chk("t2_c2", 64'(o_instr[2]), 64'h1_0000_0022);
      chk("t2_term3", 64'(o_term[3]), 64'h1);
      chk("t2_nord", 64'(cnt), 64'h0);

      // nack on w3
      setup(8'h05, 8'h2A, 10'h010, 11'd3);
      tick(0, 1, 0, 0);
      repeat (3) tick(0, 0, 0, 0);
      tick(0, 0, 0, 1);
      repeat (5) tick(0, 0, 0, 0);
      chk("t3_c5", 64'({o_instr[5][INSTR_W], o_rd_en[5], o_rd_addr[5]}),
          64'h411);
      chk("t3_c6", 64'(o_instr[6]), 64'h1_C0DE_0011);
      chk("t3_c7", 64'(o_instr[7]), 64'h1_C0DE_0012);
      chk("t3_term8", 64'(o_term[8]), 64'h1);

      // nack on w0
      setup(8'h05, 8'h2A, 10'h010, 11'd3);
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 1);
      repeat (8) tick(0, 0, 0, 0);
      chk("t4_c2", 64'({o_instr[2][INSTR_W], o_req[2], o_rd_en[2]}), 64'h2);
      chk("t4_c3", 64'(o_instr[3]), 64'h1_0000_0005);
      chk("t4_term8", 64'(o_term[8]), 64'h1);

      // address wrap
      setup(8'h01, 8'h02, 10'h3FF, 11'd2);
      tick(0, 1, 0, 0);
      repeat (6) tick(0, 0, 0, 0);
      chk("t5_rd2", 64'({o_rd_en[2], o_rd_addr[2]}), 64'h7FF);
      chk("t5_rd3", 64'({o_rd_en[3], o_rd_addr[3]}), 64'h400);
      chk("t5_c3", 64'(o_instr[3]), 64'h1_C0DE_03FF);
      chk("t5_c4", 64'(o_instr[4]), 64'h1_C0DE_0000);

      // abort and restart
      setup(8'h05, 8'h2A, 10'h010, 11'd3);
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
      d_iss = 8'h99;
      tick(0, 1, 0, 0);
      tick(0, 0, 1, 1);
      d_iss = 8'h77;
      d_tid = 8'h66;
      d_base = 10'h100;
      d_len = 11'd1;
      tick(0, 1, 0, 0);
      repeat (6) tick(0, 0, 0, 0);
      chk("t6_c3", 64'(o_instr[3]), 64'h1_C0DE_0010);
      chk("t6_c4", 64'({o_req[4], o_busy[4], o_term[4]}), 64'h0);
      chk("t6_c5", 64'(o_instr[5]), 64'h1_0000_0077);
      chk("t6_c7", 64'(o_instr[7]), 64'h1_C0DE_0100);

      // reset mid-transfer
      setup(8'h05, 8'h2A, 10'h010, 11'd3);
      tick(0, 1, 0, 0);
      repeat (2) tick(0, 0, 0, 0);
      tick(1, 0, 0, 0);
      repeat (3) tick(0, 0, 0, 0);
      chk("t7_c4", 64'({o_req[4], o_busy[4], o_term[4]}), 64'h0);
      chk("t7_c5", 64'(o_term[5]), 64'h0);

      // full-size stream with wrap
      setup(8'hAB, 8'hCD, 10'h155, 11'd1024);
      term_at = -1;
      tick(0, 1, 0, 0);
      repeat (1030) tick(0, 0, 0, 0);
      chk("t8_term", 64'(term_at), 64'd1027);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         int r;
         d_iss = ISSUE_W'($urandom);
         d_tid = ID_W'($urandom);
         d_base = ($urandom_range(0, 3) == 0) ?
                  ADDR_W'($urandom_range(1018, 1023)) :
                  ADDR_W'($urandom);
         r = $urandom_range(0, 29);
         d_len = (r == 0) ? 11'd1024 :
                 (r == 1) ? 11'd1023 :
                 11'($urandom_range(0, 6));
         tick($urandom_range(0, 299) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 59) == 0,
              $urandom_range(0, 4) == 0);
      end
      repeat (2) tick(0, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
